// File: rtl/exp7_mostra_sequencia_if.sv
// Bus between the sequence presenter and its controller / game memory.
// master: unidade de controle + memory side; slave: the presenter itself.
interface exp7_mostra_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              mostrar;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] mem_dado;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output mostrar, limite, mem_dado,
    input  endereco, leds, ocupado, pronto, db_estado
  );

  modport slave (
    input  mostrar, limite, mem_dado,
    output endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exp7_mostra_sequencia.sv
// Sequence presenter for the memory game: on a mostrar request it plays memory
// entries 0..limite on leds, each lit TEMPO_ON cycles then dark TEMPO_OFF
// cycles, and pulses pronto at the end.
// Optional feature: define MOSTRA_PAUSA_EN to add the 'pausar' input, which
// freezes the lit/dark timers while high.
module exp7_mostra_sequencia #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int TEMPO_ON  = 1000,
  parameter int TEMPO_OFF = 500
) (
  input  logic clock,
  input  logic reset,
`ifdef MOSTRA_PAUSA_EN
  input  logic pausar,
`endif
  exp7_mostra_sequencia_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    CARREGA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    FIM     = 4'hF
  } estado_t;

  // Timer only has to reach the larger of the two terminal counts.
  localparam int T_MAX = (TEMPO_ON > TEMPO_OFF) ? TEMPO_ON : TEMPO_OFF;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(TEMPO_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(TEMPO_OFF - 1);

  estado_t           state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] lim_q;
  logic [TW-1:0]     timer_q;
  logic [DATA_W-1:0] leds_q;
  logic              pausa_ativa;

`ifdef MOSTRA_PAUSA_EN
  assign pausa_ativa = pausar;
`else
  assign pausa_ativa = 1'b0;
`endif

  // Sequencer FSM: walks idx from 0 to the latched limit, timing lit and dark phases.
  // NOTE: every register here, including the FSM state, uses non-blocking
  // assignment so all of them update together from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      idx_q   <= '0;
      lim_q   <= '0;
      timer_q <= '0;
      leds_q  <= '0;
    end else begin
      unique case (state_q)
        INICIAL: begin
          if (bus.mostrar) begin
            idx_q   <= '0;
            lim_q   <= bus.limite;
            state_q <= CARREGA;
          end
        end
        CARREGA: begin
          leds_q  <= bus.mem_dado;
          timer_q <= '0;
          state_q <= ACENDE;
        end
        ACENDE: begin
          if (!pausa_ativa) begin
            if (timer_q == ON_LAST) begin
              leds_q  <= '0;
              timer_q <= '0;
              state_q <= APAGA;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        APAGA: begin
          if (!pausa_ativa) begin
            if (timer_q == OFF_LAST) begin
              timer_q <= '0;
              // Compare before increment so an all-ones limit never wraps idx.
              if (idx_q == lim_q) begin
                state_q <= FIM;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= CARREGA;
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        FIM: begin
          state_q <= INICIAL;
        end
        default: state_q <= INICIAL;
      endcase
    end
  end

  // Moore outputs decoded from state; address is the index register directly.
  assign bus.endereco  = idx_q;
  assign bus.leds      = leds_q;
  assign bus.ocupado   = (state_q != INICIAL);
  assign bus.pronto    = (state_q == FIM);
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_exp7_mostra_sequencia.sv
// Self-checking bench for exp7_mostra_sequencia (TEMPO_ON=4, TEMPO_OFF=2).
// Compiled with MOSTRA_PAUSA_EN defined it also exercises 'pausar'.
module tb_exp7_mostra_sequencia;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;
  localparam int PERIOD = 1 + T_ON + T_OFF;

  logic clock = 1'b0;
  logic reset;
`ifdef MOSTRA_PAUSA_EN
  logic pausar = 1'b0;
`endif

  always #5 clock = ~clock;

  exp7_mostra_sequencia_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign bus.mem_dado = mem[bus.endereco];

  exp7_mostra_sequencia #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEMPO_ON(T_ON), .TEMPO_OFF(T_OFF)
  ) dut (
    .clock (clock),
    .reset (reset),
`ifdef MOSTRA_PAUSA_EN
    .pausar(pausar),
`endif
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  // Reference model: m_k is the 1-based cycle position inside the running
  // sequence (0 = idle); every output follows arithmetically from it.
  int m_k    = 0;
  int m_lim  = 0;
  int m_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int total_len(input int lim);
    return (lim + 1) * PERIOD + 1;
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_k    = 0;
      m_last = 0;
    end else if (m_k == 0) begin
      if (bus.mostrar === 1'b1) begin
        m_k   = 1;
        m_lim = int'(bus.limite);
      end
    end else if (m_k == total_len(m_lim)) begin
      m_k    = 0;
      m_last = m_lim;
    end else begin
`ifdef MOSTRA_PAUSA_EN
      // Pause freezes only the lit and dark phases, not the load cycle.
      if (!(pausar && ((m_k - 1) % PERIOD) != 0)) m_k++;
`else
      m_k++;
`endif
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      logic [DATA_W-1:0] e_leds;
      logic [ADDR_W-1:0] e_addr;
      logic [3:0]        e_db;
      logic              e_oc, e_pr;
      int e, p;
      if (m_k == 0) begin
        e_leds = '0; e_addr = ADDR_W'(m_last); e_db = 4'h0; e_oc = 1'b0; e_pr = 1'b0;
      end else if (m_k == total_len(m_lim)) begin
        e_leds = '0; e_addr = ADDR_W'(m_lim); e_db = 4'hF; e_oc = 1'b1; e_pr = 1'b1;
      end else begin
        e = (m_k - 1) / PERIOD;
        p = (m_k - 1) % PERIOD;
        e_addr = ADDR_W'(e);
        e_leds = (p >= 1 && p <= T_ON) ? mem[e] : '0;
        e_db   = (p == 0) ? 4'h1 : (p <= T_ON) ? 4'h2 : 4'h3;
        e_oc   = 1'b1;
        e_pr   = 1'b0;
      end
      check("leds",      32'(bus.leds),      32'(e_leds));
      check("endereco",  32'(bus.endereco),  32'(e_addr));
      check("db_estado", 32'(bus.db_estado), 32'(e_db));
      check("ocupado",   32'(bus.ocupado),   32'(e_oc));
      check("pronto",    32'(bus.pronto),    32'(e_pr));
    end
  end

  // Start a sequence, then run until pronto; reports latency (pronto cycle,
  // counting the cycle after the sampling edge as 1) and lit-cycle count.
  task automatic run_seq(input int lim, input int pause_k, input int pause_len,
                         input bit poke, output int lat, output int on_cnt,
                         output int seen_mask);
    int s, k;
    lat = -1; on_cnt = 0; seen_mask = 0;
    @(negedge clock);
    bus.limite  = ADDR_W'(lim);
    bus.mostrar = 1'b1;
    @(negedge clock);
    bus.mostrar = 1'b0;
    s = cyc;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      k = cyc - s + 1;
`ifdef MOSTRA_PAUSA_EN
      if (k == pause_k) pausar = 1'b1;
      if (k == pause_k + pause_len) pausar = 1'b0;
`endif
      if (poke && k == 5) begin
        bus.limite  = 4'd3;
        bus.mostrar = 1'b1;
      end
      if (poke && k == 6) bus.mostrar = 1'b0;
      if (bus.leds != 0) begin
        on_cnt++;
        seen_mask |= int'(bus.leds);
      end
      if (bus.pronto) lat = k;
      else @(negedge clock);
    end
    if (lat < 0) check("pronto_timeout", 32'hFFFF_FFFF, 32'(total_len(lim)));
  endtask

  initial begin
    int lat, on_cnt, mask, pulses, waited;
    bus.mostrar = 1'b0;
    bus.limite  = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(1 << (i % DATA_W));
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 cmp_en = 1'b1;

    // 1: idle after reset
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_ocupado", 32'(bus.ocupado),   32'd0);
    check("idle_estado",  32'(bus.db_estado), 32'd0);

    // 2: single entry
    run_seq(0, 0, 0, 1'b0, lat, on_cnt, mask);
    check("lim0_latency", 32'(lat),    32'd8);
    check("lim0_on",      32'(on_cnt), 32'd4);
    @(negedge clock);
    check("lim0_ocupado_after", 32'(bus.ocupado), 32'd0);

    // 3: four entries
    run_seq(3, 0, 0, 1'b0, lat, on_cnt, mask);
    check("lim3_latency", 32'(lat),    32'd29);
    check("lim3_on",      32'(on_cnt), 32'd16);
    check("lim3_values",  32'(mask),   32'hF);
    repeat (3) @(negedge clock);

    // 4: limite change and mostrar mid-sequence are ignored
    run_seq(1, 0, 0, 1'b1, lat, on_cnt, mask);
    check("midchg_latency", 32'(lat),  32'd15);
    check("midchg_values",  32'(mask), 32'h3);
    pulses = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.pronto) pulses++;
    end
    check("midchg_no_restart", 32'(pulses), 32'd0);

    // 5: asynchronous reset during second lit phase
    @(negedge clock);
    bus.limite  = 4'd3;
    bus.mostrar = 1'b1;
    @(negedge clock);
    bus.mostrar = 1'b0;
    waited = 0;
    while (!(bus.db_estado == 4'h2 && bus.endereco == 4'd1) && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("second_acende_reached", 32'(waited < 100), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_leds",  32'(bus.leds),      32'd0);
    check("async_estado",32'(bus.db_estado), 32'd0);
    check("async_addr",  32'(bus.endereco),  32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("post_reset_idle", 32'(bus.ocupado), 32'd0);

`ifdef MOSTRA_PAUSA_EN
    // 6: pause for 10 cycles at the second lit cycle
    run_seq(0, 3, 10, 1'b0, lat, on_cnt, mask);
    check("pause_latency", 32'(lat),    32'd18);
    check("pause_on",      32'(on_cnt), 32'd14);
    @(negedge clock);
`endif

    // Random phase: random memory, requests, limits and rare resets.
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
    repeat (3000) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) bus.mostrar = ~bus.mostrar;
      bus.limite = ADDR_W'($urandom);
`ifdef MOSTRA_PAUSA_EN
      pausar = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
      end
    end
    bus.mostrar = 1'b0;
`ifdef MOSTRA_PAUSA_EN
    pausar = 1'b0;
`endif
    repeat (300) @(negedge clock);
    check("final_idle", 32'(bus.ocupado), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
